// File: rtl/conv_pad_stream.sv
// Streaming 2-D convolution over a zero-padded square image with a stored, reusable kernel.
// Latency: result registered one edge after the window-completing scan position advances.
// Backpressure: the scan (pad or pixel) stalls while the single output register is held.
module conv_pad_stream #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int M  = 3,
    parameter int P  = 1,
    parameter int AW = 2*DW+$clog2(M*M)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          start,
    input  logic          reuse_k,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] result,
    output logic          done
);
    localparam int Q  = N + 2*P;
    localparam int L  = (M-1)*Q + M;
    localparam int MM = M*M;
    localparam int CW = $clog2(Q+1);
    localparam int KW = $clog2(MM+1);
    localparam int PW = 2*DW;

    localparam logic [CW-1:0] P_LO   = CW'(P);
    localparam logic [CW-1:0] P_HI   = CW'(N+P);
    localparam logic [CW-1:0] W_LO   = CW'(M-1);
    localparam logic [CW-1:0] LAST   = CW'(Q-1);
    localparam logic [KW-1:0] K_LAST = KW'(MM-1);

    typedef enum logic [2:0] {IDLE, LOAD_K, STREAM, DRAIN, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         r, c;
    logic [KW-1:0]         kcnt;
    logic signed [DW-1:0]  k   [MM];
    logic signed [DW-1:0]  sr  [L];
    logic signed [DW-1:0]  nxt [L];
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc;
    logic                  slot_free, is_image, adv, win_done, last_pos;

    always_comb begin
        slot_free = !out_valid || out_ready;
        is_image  = (r >= P_LO) && (r < P_HI) && (c >= P_LO) && (c < P_HI);
        in_ready  = (state == LOAD_K) || (state == STREAM && is_image && slot_free);
        adv       = (state == STREAM) && slot_free && (!is_image || in_valid);
        win_done  = (r >= W_LO) && (c >= W_LO);
        last_pos  = (r == LAST) && (c == LAST);

        // One delay line of (M-1) rows plus M taps; newest sample sits at index 0.
        nxt[0] = is_image ? $signed(in_data) : '0;
        for (int i = 1; i < L; i++) nxt[i] = sr[i-1];

        prod = '0;
        acc  = '0;
        for (int a = 0; a < M; a++) begin
            for (int b = 0; b < M; b++) begin
                prod = PW'(k[a*M+b]) * PW'(nxt[(M-1-a)*Q + (M-1-b)]);
                acc  = acc + AW'(prod);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            kcnt      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            for (int i = 0; i < MM; i++) k[i]  <= '0;
            for (int i = 0; i < L;  i++) sr[i] <= '0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (adv) begin
                for (int i = 0; i < L; i++) sr[i] <= nxt[i];
                if (win_done) begin
                    out_valid <= 1'b1;
                    result    <= acc;
                end
                if (c == LAST) begin
                    c <= '0;
                    r <= r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        r     <= '0;
                        c     <= '0;
                        kcnt  <= '0;
                        state <= reuse_k ? STREAM : LOAD_K;
                    end
                end
                LOAD_K: begin
                    if (in_valid) begin
                        // Shift in from the top so k[0] ends up holding the first word.
                        for (int i = 0; i < MM-1; i++) k[i] <= k[i+1];
                        k[MM-1] <= $signed(in_data);
                        kcnt    <= kcnt + 1'b1;
                        if (kcnt == K_LAST) state <= STREAM;
                    end
                end
                STREAM: begin
                    if (adv && last_pos) state <= DRAIN;
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_pad_stream.sv
// Directed bench for conv_pad_stream: identity, box, backpressure, kernel reuse,
// extreme-value and mid-frame reset frames against hand-computed results.
module tb_conv_pad_stream;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int M  = 3;
    localparam int P  = 1;
    localparam int AW = 2*DW+$clog2(M*M);

    logic          clock = 1'b0;
    logic          rst_n;
    logic          start, reuse_k, in_valid, in_ready, out_valid, out_ready, done;
    logic [DW-1:0] in_data;
    logic [AW-1:0] result;

    always #5 clock = ~clock;

    conv_pad_stream #(.DW(DW), .N(N), .M(M), .P(P)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .reuse_k   (reuse_k),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .done      (done)
    );

    int          errs = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [15:0] kern [9];
    logic [15:0] img  [16];
    longint      expv [16];
    longint      ones_tab [16] = '{4,6,6,4, 6,9,9,6, 6,9,9,6, 4,6,6,4};
    longint      box_tab  [16] = '{14,24,30,22, 33,54,63,45, 57,90,99,69, 46,72,78,54};

    always @(negedge clock) if (done) done_cnt++;

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"},  longint'(in_ready),  0);
        check({tag, " out_valid"}, longint'(out_valid), 0);
        check({tag, " result"},    longint'(result),    0);
        check({tag, " done"},      longint'(done),      0);
    endtask

    task automatic run_frame(input bit load, input bit slow, input int abort_at, input string name);
        int     widx, nk, holdbad, d0, cyc;
        longint got [$];
        widx = 0; holdbad = 0; d0 = done_cnt;
        nk = load ? 9 : 0;
        @(negedge clock);
        start = 1'b1; reuse_k = ~load;
        @(negedge clock);
        start = 1'b0; reuse_k = 1'b0;
        for (cyc = 0; cyc < 600; cyc++) begin
            out_ready = slow ? (cyc % 2 == 0) : 1'b1;
            in_valid  = (widx < nk + 16) && (!slow || $urandom_range(0, 2) != 0);
            if (widx < nk)           in_data = kern[widx];
            else if (widx < nk + 16) in_data = img[widx - nk];
            #1;
            if (out_valid && !out_ready && in_ready) holdbad++;
            if (out_valid && out_ready) got.push_back(longint'($signed(result)));
            if (done) break;
            if (in_valid && in_ready) begin
                widx++;
                if (abort_at != 0 && widx == abort_at) break;
            end
            @(negedge clock);
        end
        if (abort_at != 0) begin
            @(negedge clock);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        if (cyc >= 600) check({name, " timeout"}, 0, 1);
        check({name, " count"}, got.size(), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s r%0d", name, i), (i < got.size()) ? got[i] : -1, expv[i]);
        if (slow) check({name, " held_in_ready"}, holdbad, 0);
        repeat (2) @(negedge clock);
        check({name, " done_pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d_abort;
        rst_n = 1'b0; start = 1'b0; reuse_k = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_idle("reset");
        rst_n = 1'b1;

        // Identity kernel reproduces the image.
        for (int i = 0; i < 9; i++)  kern[i] = (i == 4) ? 16'd1 : 16'd0;
        for (int i = 0; i < 16; i++) begin img[i] = 16'(i + 1); expv[i] = i + 1; end
        run_frame(1'b1, 1'b0, 0, "ident");

        for (int i = 0; i < 9; i++)  kern[i] = 16'd1;
        for (int i = 0; i < 16; i++) begin img[i] = 16'd1; expv[i] = ones_tab[i]; end
        run_frame(1'b1, 1'b0, 0, "ones");
        run_frame(1'b1, 1'b1, 0, "ones_bp");

        // Stored all-ones kernel reused: first word must be pixel (0,0).
        for (int i = 0; i < 16; i++) begin img[i] = 16'(i + 1); expv[i] = box_tab[i]; end
        run_frame(1'b0, 1'b0, 0, "reuse");

        for (int i = 0; i < 9; i++)  kern[i] = 16'h8000;
        for (int i = 0; i < 16; i++) begin img[i] = 16'h8000; expv[i] = ones_tab[i] * (64'sd1 <<< 30); end
        run_frame(1'b1, 1'b0, 0, "minval");

        // Abort after the 7th pixel (9 kernel words + 7 pixels).
        for (int i = 0; i < 9; i++)  kern[i] = (i == 4) ? 16'd1 : 16'd0;
        for (int i = 0; i < 16; i++) begin img[i] = 16'(i + 1); expv[i] = i + 1; end
        d_abort = done_cnt;
        run_frame(1'b1, 1'b0, 16, "abort");
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        #1 check_idle("abort");
        repeat (5) @(negedge clock);
        check("abort no_done", done_cnt - d_abort, 0);
        run_frame(1'b1, 1'b0, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/conv_pad_stream.md
# conv_pad_stream

Streaming 2-D convolution engine with internally generated zero padding and valid/ready handshakes on both sides. It is the parametrised successor to the fixed 3×3-image / 2×2-kernel padded convolver. Image size, kernel size, padding depth and data width are parameters, and a kernel can be reused across frames. It sits between a pixel source (DMA/line feeder) and a result sink, and produces one full-precision signed sum per output pixel in raster order.

## Interface
- `DW`, 16: signed data width of kernel and pixel words.
- `N`, 4: image height and width (square image), N ≥ 2.
- `M`, 3: kernel height and width (square kernel), 1 ≤ M ≤ N+2P.
- `P`, 1: zero-padding rows/columns on each side, 0 ≤ P < M.
- `AW`, 2*DW+$clog2(M*M): result width. Derived; do not override.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle frame request; honoured only in IDLE.
- `reuse_k`  in  1  sampled with `start`; 1 means skip kernel load and keep the stored kernel.
- `in_valid`  in  1  source has a word on `in_data`.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `in_data`  in  DW  kernel word (LOAD_K) or image pixel (STREAM), signed, row-major.
- `out_valid`  out  1  `result` holds a valid output pixel.
- `out_ready`  in  1  sink accepts `result`.
- `result`  out  AW  signed convolution sum.
- `done`  out  1  one-cycle pulse after the last result of a frame is accepted.

## Operation
- States: IDLE, LOAD_K, STREAM, DRAIN, DONE.
- IDLE: `in_ready`=0. On `start`, go to LOAD_K if `reuse_k`=0, else go to STREAM.
- LOAD_K: `in_ready`=1. Accept M*M words into kernel regs k[0..M*M-1] in row-major order. After the last accepted word, go to STREAM.
- STREAM: a scan pointer (r,c) walks the padded frame of Q=N+2P rows × Q cols, row-major.
  - Pad positions (r<P, r≥N+P, c<P, c≥N+P): a zero is inserted internally, no input is consumed, `in_ready`=0.
  - Image positions: `in_ready`=1 when the output slot is free. The pointer advances on `in_valid && in_ready`.
  - Every advanced position shifts the value into a window fed by M-1 line buffers of depth Q.
  - When an advanced position has r≥M-1 and c≥M-1, the window's bottom-right corner has completed. The window is multiplied elementwise with k, summed, and written to the output register.
  - After position (Q-1,Q-1) advances, go to DRAIN.
- DRAIN: `in_ready`=0. Wait for the held result to be accepted, then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE. The kernel is retained.
- Output count per frame is O×O with O=Q-M+1, in raster order. For window (i,j), result = Σ k[a*M+b]·x[i+a][j+b] over the padded image x.
- Arithmetic: signed multiply DW×DW→2DW; accumulation sign-extended to AW. No rounding, no saturation, no overflow possible.
- Output slot: a single register. It is free when `out_valid`=0 or `out_valid && out_ready` in the same cycle.
- The scan pointer does not advance, pad or real, while the slot is not free.
- `start` outside IDLE is ignored. `in_data` outside LOAD_K/STREAM image positions is ignored.
- `reuse_k`=1 after reset, before any kernel has been loaded, uses an all-zero kernel (kernel regs reset to 0).

## Timing
- Reset: `in_ready`=0, `out_valid`=0, `result`=0, `done`=0, state IDLE. Kernel, line buffers and pointers are cleared.
- `rst_n` asserted mid-frame aborts immediately. No `done` is generated and the partial frame is discarded.
- `start` at edge t: `in_ready`=1 from t+1 (LOAD_K, or STREAM at an image position). A pad position at t+1 advances with `in_ready`=0.
- Pad positions cost one cycle each when the slot is free. Minimum frame time in STREAM is Q*Q cycles.
- Latency: `out_valid` rises on the edge after the completing position advances, with `result` registered.
- `out_valid` and `result` stay stable until `out_ready`. Accept and a new result can occur on the same edge, giving back-to-back one result per cycle.
- `done` is asserted on the cycle after the edge at which the last result is accepted.

## Test plan
- Identity kernel (k[4]=1, others 0), image 1..16 row-major, `out_ready`=1 → 16 results equal 1..16 in order. `done` pulses once.
- All-ones kernel and all-ones image (DW=16, N=4, M=3, P=1) → results 4,6,6,4 / 6,9,9,6 / 6,9,9,6 / 4,6,6,4.
- Repeat the previous case with `out_ready` alternating 1,0 and `in_valid` randomly gapped → identical 16 results. No result is lost or duplicated. `in_ready`=0 while a result is held.
- Second frame with `start`, `reuse_k`=1 → the first accepted word is treated as pixel (0,0). Results match the first frame with the same kernel.
- Kernel and image all −32768 → interior results = 9·2^30 = 9663676416, corner results 4·2^30, no wrap at AW=36.
- `rst_n` low for 1 cycle after the 7th pixel → all outputs 0, no `done`. A following full frame produces correct results.
